// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin share of one AXI read channel between icache and dcache
module axi_rd_arbiter #(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter logic [3:0]  ID_I   = 4'd0,
  parameter logic [3:0]  ID_D   = 4'd1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_arvalid,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [7:0]        i_arlen,
  output logic              i_arready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rlast,
  input  logic              i_rready,
  input  logic              d_arvalid,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [7:0]        d_arlen,
  output logic              d_arready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rlast,
  input  logic              d_rready,
  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [3:0]        m_arid,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  output logic              m_rready,
  output logic              len_err
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_RD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic              owner_q, owner_d;         // 0 = icache, 1 = dcache
  logic              last_grant_q, last_grant_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              len_err_q, len_err_d;
  logic              grant;

  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign len_err   = len_err_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    len_err_d    = 1'b0;
    grant        = 1'b0;
    m_arvalid    = 1'b0;
    m_araddr     = '0;
    m_arlen      = '0;
    m_arid       = '0;
    m_rready     = 1'b0;
    i_arready    = 1'b0;
    d_arready    = 1'b0;
    i_rvalid     = 1'b0;
    d_rvalid     = 1'b0;
    i_rlast      = 1'b0;
    d_rlast      = 1'b0;
    i_rdata      = m_rdata;
    d_rdata      = m_rdata;

    case (state_q)
      S_IDLE: begin
        if (i_arvalid || d_arvalid) begin
          grant        = (i_arvalid && d_arvalid) ? ~last_grant_q : d_arvalid;
          owner_d      = grant;
          last_grant_d = grant;
          addr_d       = grant ? d_araddr : i_araddr;
          len_d        = grant ? d_arlen : i_arlen;
          state_d      = S_AR;
        end
      end
      S_AR: begin
        m_arvalid = 1'b1;
        m_araddr  = addr_q;
        m_arlen   = len_q;
        m_arid    = owner_q ? ID_D : ID_I;
        if (m_arready) begin
          i_arready = ~owner_q;
          d_arready = owner_q;
          cnt_d     = '0;
          state_d   = S_RD;
        end
      end
      S_RD: begin
        m_rready = owner_q ? d_rready : i_rready;
        i_rvalid = ~owner_q & m_rvalid;
        d_rvalid = owner_q & m_rvalid;
        i_rlast  = ~owner_q & m_rlast;
        d_rlast  = owner_q & m_rlast;
        if (m_rvalid && m_rready) begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          if (m_rlast) begin
            // beats seen including this one is cnt_q+1, expected is len_q+1
            len_err_d = (cnt_q != len_q);
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      len_err_q    <= len_err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed vector table plus multi-cycle sequences for axi_rd_arbiter
module tb_axi_rd_arbiter;

  localparam logic [31:0] IA = 32'h1C00_0010;
  localparam logic [31:0] DA = 32'h2000_0040;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
  logic [31:0] i_araddr, i_rdata;
  logic [7:0]  i_arlen;
  logic        d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
  logic [31:0] d_araddr, d_rdata;
  logic [7:0]  d_arlen;
  logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready, len_err;
  logic [31:0] m_araddr, m_rdata;
  logic [7:0]  m_arlen;
  logic [3:0]  m_arid;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .rstn(rstn),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rready(i_rready),
    .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arready(d_arready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rready(d_rready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rready(m_rready),
    .len_err(len_err)
  );

  typedef struct {
    logic rstn, iv; logic [7:0] ilen; logic irr, dv; logic [7:0] dlen; logic drr;
    logic mar, mrv; logic [7:0] mrd; logic mrl;
    logic e_arv; logic [31:0] e_addr; logic [7:0] e_len; logic [3:0] e_id;
    logic e_rr, e_iar, e_irv, e_irl, e_dar, e_drv, e_drl, e_lerr;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] rx[$];

  task automatic add(input logic r, iv, input logic [7:0] ilen, input logic irr, dv,
                     input logic [7:0] dlen, input logic drr, mar, mrv, input logic [7:0] mrd,
                     input logic mrl, arv, input logic [31:0] addr, input logic [7:0] len,
                     input logic [3:0] id, input logic rr, iar, irv, irl, dar, drv, drl, lerr);
    vec_t v;
    v = '{r, iv, ilen, irr, dv, dlen, drr, mar, mrv, mrd, mrl,
          arv, addr, len, id, rr, iar, irv, irl, dar, drv, drl, lerr};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_arvalid = 0; i_arlen = 0; i_rready = 0;
    d_arvalid = 0; d_arlen = 0; d_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rlast = 0;
  endtask

  task automatic wait_ar(input string nm, input int limit);
    bit seen;
    seen = 0;
    for (int n = 0; n < limit && !seen; n++) begin
      @(negedge clk);
      if (m_arvalid) seen = 1;
      else step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: m_arvalid never rose within %0d cycles", nm, limit);
    end
  endtask

  // starts and ends at posedge+1; expects the FSM already in RD for the icache
  task automatic beats_i(input string nm, input int n, input logic [31:0] base);
    i_rready = 1;
    for (int k = 0; k < n; k++) begin
      m_rvalid = 1; m_rdata = base + k; m_rlast = (k == n - 1);
      @(negedge clk);
      chk($sformatf("%s_beat%0d", nm, k), {i_rvalid, i_rdata, i_rlast, d_rvalid, m_rready},
          {1'b1, base + k, (k == n - 1), 1'b0, 1'b1});
      step();
    end
    m_rvalid = 0; m_rlast = 0;
    @(negedge clk);
    chk({nm, "_end"}, {i_rvalid, m_rready, len_err}, 3'b000);
    step();
  endtask

  initial begin
    // rstn iv ilen irr dv dlen drr mar mrv mrd mrl | arv addr len id rr iar irv irl dar drv drl lerr
    // icache alone, 4 beats
    add(1,1,3,1, 0,0,0, 1,0,8'h00,0,  0,0 ,0,0, 0,0,0,0, 0,0,0,0);
    add(1,1,3,1, 0,0,0, 1,0,8'h00,0,  1,IA,3,0, 0,1,0,0, 0,0,0,0);
    add(1,0,0,1, 0,0,0, 1,1,8'hA0,0,  0,0 ,0,0, 1,0,1,0, 0,0,0,0);
    add(1,0,0,1, 0,0,0, 1,1,8'hA1,0,  0,0 ,0,0, 1,0,1,0, 0,0,0,0);
    add(1,0,0,1, 0,0,0, 1,1,8'hA2,0,  0,0 ,0,0, 1,0,1,0, 0,0,0,0);
    add(1,0,0,1, 0,0,0, 1,1,8'hA3,1,  0,0 ,0,0, 1,0,1,1, 0,0,0,0);
    add(1,0,0,0, 0,0,0, 0,0,8'h00,0,  0,0 ,0,0, 0,0,0,0, 0,0,0,0);
    // reset, then simultaneous requests: I first, then D
    add(0,0,0,0, 0,0,0, 0,0,8'h00,0,  0,0 ,0,0, 0,0,0,0, 0,0,0,0);
    add(1,1,1,1, 1,1,0, 1,0,8'h00,0,  0,0 ,0,0, 0,0,0,0, 0,0,0,0);
    add(1,1,1,1, 1,1,0, 1,0,8'h00,0,  1,IA,1,0, 0,1,0,0, 0,0,0,0);
    add(1,0,0,1, 1,1,0, 1,1,8'hB0,0,  0,0 ,0,0, 1,0,1,0, 0,0,0,0);
    add(1,0,0,1, 1,1,0, 1,1,8'hB1,1,  0,0 ,0,0, 1,0,1,1, 0,0,0,0);
    add(1,0,0,0, 1,1,1, 1,0,8'h00,0,  0,0 ,0,0, 0,0,0,0, 0,0,0,0);
    add(1,0,0,0, 1,1,1, 1,0,8'h00,0,  1,DA,1,1, 0,0,0,0, 1,0,0,0);
    add(1,0,0,0, 0,0,1, 1,1,8'hC0,0,  0,0 ,0,0, 1,0,0,0, 0,1,0,0);
    add(1,0,0,0, 0,0,1, 1,1,8'hC1,1,  0,0 ,0,0, 1,0,0,0, 0,1,1,0);
    add(1,0,0,0, 0,0,0, 0,0,8'h00,0,  0,0 ,0,0, 0,0,0,0, 0,0,0,0);
    // dcache arlen=3 with early rlast on beat 2
    add(1,0,0,0, 1,3,1, 1,0,8'h00,0,  0,0 ,0,0, 0,0,0,0, 0,0,0,0);
    add(1,0,0,0, 1,3,1, 1,0,8'h00,0,  1,DA,3,1, 0,0,0,0, 1,0,0,0);
    add(1,0,0,0, 0,0,1, 1,1,8'hD0,0,  0,0 ,0,0, 1,0,0,0, 0,1,0,0);
    add(1,0,0,0, 0,0,1, 1,1,8'hD1,1,  0,0 ,0,0, 1,0,0,0, 0,1,1,0);
    add(1,0,0,0, 0,0,0, 0,0,8'h00,0,  0,0 ,0,0, 0,0,0,0, 0,0,0,1);
    add(1,0,0,0, 0,0,0, 0,0,8'h00,0,  0,0 ,0,0, 0,0,0,0, 0,0,0,0);

    i_araddr = IA; d_araddr = DA;
    idle_inputs();
    rstn = 0;
    step(); step();
    rstn = 1;
    @(negedge clk);
    chk("reset_state", {m_arvalid, m_araddr, m_arlen, m_arid, m_rready, i_arready, d_arready,
                        i_rvalid, d_rvalid, i_rlast, d_rlast, len_err, m_arsize, m_arburst},
        {1'b0, 32'h0, 8'h0, 4'h0, 8'h00, 3'b010, 2'b01});
    step();

    foreach (vecs[n]) begin
      rstn = vecs[n].rstn;
      i_arvalid = vecs[n].iv; i_arlen = vecs[n].ilen; i_rready = vecs[n].irr;
      d_arvalid = vecs[n].dv; d_arlen = vecs[n].dlen; d_rready = vecs[n].drr;
      m_arready = vecs[n].mar; m_rvalid = vecs[n].mrv;
      m_rdata = {24'h0, vecs[n].mrd}; m_rlast = vecs[n].mrl;
      @(negedge clk);
      chk($sformatf("vec%0d", n),
          {m_arvalid, m_araddr, m_arlen, m_arid, m_rready, i_arready, i_rvalid, i_rlast,
           d_arready, d_rvalid, d_rlast, len_err, i_rdata, d_rdata},
          {vecs[n].e_arv, vecs[n].e_addr, vecs[n].e_len, vecs[n].e_id, vecs[n].e_rr,
           vecs[n].e_iar, vecs[n].e_irv, vecs[n].e_irl, vecs[n].e_dar, vecs[n].e_drv,
           vecs[n].e_drl, vecs[n].e_lerr, {24'h0, vecs[n].mrd}, {24'h0, vecs[n].mrd}});
      step();
    end
    idle_inputs();
    rstn = 1;

    // AR backpressure then owner rready toggling
    i_arvalid = 1; i_arlen = 2;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), {m_arvalid, m_araddr, i_arready}, {1'b1, IA, 1'b0});
      step();
    end
    m_arready = 1;
    @(negedge clk);
    chk("bp_arready", {m_arvalid, i_arready}, 2'b11);
    step();
    i_arvalid = 0; m_arready = 0;
    begin
      int acc;
      acc = 0;
      for (int c = 0; c < 5; c++) begin
        i_rready = (c % 2 == 0);
        m_rvalid = 1; m_rdata = 32'hE0 + acc; m_rlast = (acc == 2);
        @(negedge clk);
        chk($sformatf("bp_rready%0d", c), {m_rready, i_rvalid}, {i_rready, 1'b1});
        if (i_rvalid && i_rready) rx.push_back(i_rdata);
        if (i_rready) acc++;
        step();
      end
    end
    idle_inputs();
    @(negedge clk);
    chk("bp_count", rx.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < rx.size()) chk($sformatf("bp_data%0d", k), rx[k], 32'hE0 + k);
    chk("bp_idle", {m_rready, i_rvalid, len_err}, 3'b000);
    step();

    // reset during beat 2 of 4
    i_arvalid = 1; i_arlen = 3; i_rready = 1; m_arready = 1;
    step();
    i_arvalid = 0;
    step();
    m_rvalid = 1; m_rdata = 32'h40;
    step();
    m_rdata = 32'h41; rstn = 0;
    step();
    rstn = 1; m_rdata = 32'h42;
    @(negedge clk);
    chk("rst_idle", {m_arvalid, m_araddr, m_rready, i_rvalid, i_rlast, d_rvalid, i_arready, len_err},
        {1'b0, 32'h0, 6'b000000});
    step();
    idle_inputs();
    i_arvalid = 1; i_arlen = 3; m_arready = 1;
    wait_ar("rst_new_ar", 10);
    chk("rst_new_arready", {i_arready, m_araddr, m_arid}, {1'b1, IA, 4'd0});
    step();
    i_arvalid = 0; m_arready = 0;
    beats_i("rst_new", 4, 32'h50);

    // requester drops arvalid while AR is stalled
    i_arvalid = 1; i_arlen = 3; m_arready = 0;
    step();
    i_arvalid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("drop_hold%0d", k), {m_arvalid, m_araddr, m_arlen}, {1'b1, IA, 8'd3});
      step();
    end
    m_arready = 1;
    @(negedge clk);
    chk("drop_arready", i_arready, 1'b1);
    step();
    m_arready = 0;
    beats_i("drop", 4, 32'h60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
